// File: rtl/decoder_16_fifo_if.sv
// Handshake bundle for decoder_16_fifo: index push side, one-hot pop side and occupancy.
// DECODER_NULL_EN adds the in_null flag that marks an entry as "no line".
interface decoder_16_fifo_if #(
    parameter int DEPTH = 4
);
    logic                     in_valid;
    logic                     in_ready;
    logic [3:0]               in_index;
`ifdef DECODER_NULL_EN
    logic                     in_null;
`endif
    logic                     out_valid;
    logic                     out_ready;
    logic [15:0]              out_onehot;
    logic [$clog2(DEPTH):0]   count;

    modport master (
        output in_valid, in_index,
`ifdef DECODER_NULL_EN
        output in_null,
`endif
        output out_ready,
        input  in_ready, out_valid, out_onehot, count
    );

    modport slave (
        input  in_valid, in_index,
`ifdef DECODER_NULL_EN
        input  in_null,
`endif
        input  out_ready,
        output in_ready, out_valid, out_onehot, count
    );
endinterface

// File: rtl/decoder_16_fifo.sv
// Buffered 4-to-16 one-hot decoder: queues 4-bit indices, presents the head as a one-hot word.
// Latency: an index accepted on edge N is visible after edge N (no bypass); one push + one pop per cycle.
// Backpressure: in_ready = count < DEPTH, out_valid = count > 0, both from registered count only. Optional DECODER_NULL_EN.
module decoder_16_fifo #(
    parameter int DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    decoder_16_fifo_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
`ifdef DECODER_NULL_EN
    localparam int EW = 5;
`else
    localparam int EW = 4;
`endif
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [EW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] cnt;
    logic [EW-1:0] wr_entry;
    logic [EW-1:0] head;
    logic          push;
    logic          pop;

    assign bus.in_ready  = (cnt < FULL);
    assign bus.out_valid = (cnt != '0);
    assign bus.count     = cnt;

    assign push = bus.in_valid && bus.in_ready;
    assign pop  = bus.out_valid && bus.out_ready;

`ifdef DECODER_NULL_EN
    assign wr_entry = {bus.in_null, bus.in_index};
`else
    assign wr_entry = bus.in_index;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    // Storage is not reset; only pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (push && !reset) mem[wr_ptr] <= wr_entry;
    end

    always_comb begin
        head           = mem[rd_ptr];
        bus.out_onehot = 16'h0000;
        if (bus.out_valid) begin
`ifdef DECODER_NULL_EN
            if (!head[4]) bus.out_onehot = 16'h0001 << head[3:0];
`else
            bus.out_onehot = 16'h0001 << head;
`endif
        end
    end
endmodule

// File: tb/tb_decoder_16_fifo.sv
// Bench for decoder_16_fifo: directed test-plan steps then random traffic against a queue model.
// Builds with or without DECODER_NULL_EN.
module tb_decoder_16_fifo;
    localparam int DEPTH = 4;

    logic clk;
    logic reset;
    int   errors = 0;
    int   checks = 0;
    int   q[$];     // model contents: 0..15 index, 16 = null entry

    decoder_16_fifo_if #(.DEPTH(DEPTH)) bus ();

    decoder_16_fifo #(.DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] model_onehot();
        if (q.size() == 0) return 16'h0000;
        if (q[0] == 16) return 16'h0000;
        return 16'h0001 << q[0];
    endfunction

    task automatic check_model();
        check("count",      32'(bus.count),      32'(q.size()));
        check("in_ready",   32'(bus.in_ready),   32'(q.size() < DEPTH));
        check("out_valid",  32'(bus.out_valid),  32'(q.size() > 0));
        check("out_onehot", 32'(bus.out_onehot), 32'(model_onehot()));
    endtask

    // Drive one cycle of inputs, advance the model across the edge, compare #1 after it.
    task automatic step(input bit rst, input bit vld, input logic [3:0] idx,
                        input bit nul, input bit rdy);
        bit do_push;
        bit do_pop;
        reset         = rst;
        bus.in_valid  = vld;
        bus.in_index  = idx;
`ifdef DECODER_NULL_EN
        bus.in_null   = nul;
`endif
        bus.out_ready = rdy;
        do_push = !rst && vld && (q.size() < DEPTH);
        do_pop  = !rst && rdy && (q.size() > 0);
        @(posedge clk);
        if (rst) q.delete();
        else begin
            if (do_pop)  void'(q.pop_front());
            if (do_push) q.push_back(nul ? 16 : int'(idx));
        end
        #1;
        check_model();
    endtask

    initial begin
        logic [15:0] drain_exp [4];
        bit nul_r;
        drain_exp[0] = 16'h0008; drain_exp[1] = 16'h0080;
        drain_exp[2] = 16'h0200; drain_exp[3] = 16'h8000;

        // Reset then idle
        step(1, 0, 4'd0, 0, 0);
        step(1, 1, 4'd9, 0, 1);
        step(0, 0, 4'd0, 0, 0);
        check("idle_count",  32'(bus.count), 32'd0);
        check("idle_ready",  32'(bus.in_ready), 32'd1);
        check("idle_onehot", 32'(bus.out_onehot), 32'h0000);

        // Stream 0..15 with consumer always ready
        for (int i = 0; i < 16; i++) begin
            step(0, 1, 4'(i), 0, 1);
            check("stream_onehot", 32'(bus.out_onehot), 32'h1 << i);
            check("stream_count",  32'(bus.count), 32'd1);
        end
        step(0, 0, 4'd0, 0, 1);
        check("stream_drained", 32'(bus.count), 32'd0);

        // Fill with consumer stalled, extra push ignored, then drain
        step(0, 1, 4'd3, 0, 0);
        step(0, 1, 4'd7, 0, 0);
        step(0, 1, 4'd9, 0, 0);
        step(0, 1, 4'd15, 0, 0);
        check("full_count", 32'(bus.count), 32'd4);
        check("full_ready", 32'(bus.in_ready), 32'd0);
        step(0, 1, 4'd1, 0, 0);
        check("full_ignored", 32'(bus.count), 32'd4);
        check("stall_hold",   32'(bus.out_onehot), 32'h0008);
        for (int i = 0; i < 4; i++) begin
            check("drain_onehot", 32'(bus.out_onehot), 32'(drain_exp[i]));
            step(0, 0, 4'd0, 0, 1);
        end
        check("drain_count", 32'(bus.count), 32'd0);

        // Full with push and pop together: pop only, push lands next cycle
        for (int i = 0; i < 4; i++) step(0, 1, 4'(i + 4), 0, 0);
        step(0, 1, 4'd12, 0, 1);
        check("full_both_count", 32'(bus.count), 32'd3);
        step(0, 1, 4'd12, 0, 0);
        check("full_retry_count", 32'(bus.count), 32'd4);
        for (int i = 0; i < 4; i++) step(0, 0, 4'd0, 0, 1);

        // Mid-operation reset discards entries
        step(0, 1, 4'd5, 0, 0);
        step(0, 1, 4'd6, 0, 0);
        step(1, 1, 4'd7, 0, 1);
        check("rst_count", 32'(bus.count), 32'd0);
        check("rst_valid", 32'(bus.out_valid), 32'd0);
        step(0, 1, 4'd2, 0, 0);
        check("post_rst_onehot", 32'(bus.out_onehot), 32'h0004);
        step(0, 0, 4'd0, 0, 1);

`ifdef DECODER_NULL_EN
        step(0, 1, 4'd0, 1, 0);
        step(0, 1, 4'd0, 0, 0);
        check("null_valid",  32'(bus.out_valid), 32'd1);
        check("null_onehot", 32'(bus.out_onehot), 32'h0000);
        step(0, 0, 4'd0, 0, 1);
        check("after_null_onehot", 32'(bus.out_onehot), 32'h0001);
        step(0, 0, 4'd0, 0, 1);
`endif

        // Random traffic with occasional reset
        for (int n = 0; n < 400; n++) begin
`ifdef DECODER_NULL_EN
            nul_r = ($urandom_range(0, 5) == 0);
`else
            nul_r = 1'b0;
`endif
            step($urandom_range(0, 59) == 0, $urandom_range(0, 2) != 0,
                 4'($urandom_range(0, 15)), nul_r, $urandom_range(0, 2) != 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
